// File: rtl/clk_div_monitor_if.sv
// Divided-clock monitor interface. The master drives the clock under test and reads the
// measurements back. The slave is the monitor that produces those measurements.
interface clk_div_monitor_if #(
    parameter int CNT_W = 8
);
    logic             div_clk;
    logic [CNT_W-1:0] hi_len;
    logic [CNT_W-1:0] lo_len;
    logic             meas_valid;
    logic             locked;
    logic             err;

    modport master (
        output div_clk,
        input  hi_len, lo_len, meas_valid, locked, err
    );

    modport slave (
        input  div_clk,
        output hi_len, lo_len, meas_valid, locked, err
    );
endinterface

// File: rtl/clk_div_monitor.sv
// Receive-side checker for a divide-by-2N clock. It measures the high and low run lengths of
// div_clk in i_clk cycles, reports every completed period, and tracks lock and errors.
module clk_div_monitor #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 3,
    parameter int CNT_W    = 8,
    parameter int SYNC     = 2
) (
    input  logic             i_clk,
    input  logic             rst_n,
    clk_div_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } state_e;

    localparam int               MW       = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] N_VAL    = CNT_W'(N);
    localparam logic [MW-1:0]    LOCK_VAL = MW'(LOCK_CNT);
    localparam logic [MW-1:0]    MATCH_1  = MW'(1);

    logic [SYNC-1:0]  sync_q;
    logic [SYNC-1:0]  prime_q;
    logic             s_q;
    state_e           state_q,      state_d;
    logic [CNT_W-1:0] run_cnt_q,    run_cnt_d;
    logic [CNT_W-1:0] hi_tmp_q,     hi_tmp_d;
    logic [CNT_W-1:0] hi_len_q,     hi_len_d;
    logic [CNT_W-1:0] lo_len_q,     lo_len_d;
    logic [MW-1:0]    match_q,      match_d;
    logic             locked_q,     locked_d;
    logic             meas_valid_q, meas_valid_d;
    logic             err_q,        err_d;

    logic             s;
    logic             rise;
    logic             fall;
    logic             primed;
    logic [MW-1:0]    match_inc;

    // The synchroniser holds reset zeros until it has been refilled; primed keeps IDLE from
    // mistaking those zeros for a real low level on div_clk.
    assign s      = sync_q[SYNC-1];
    assign primed = prime_q[SYNC-1];
    assign rise   = s & ~s_q;
    assign fall   = ~s & s_q;

    // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        run_cnt_d    = run_cnt_q;
        hi_tmp_d     = hi_tmp_q;
        hi_len_d     = hi_len_q;
        lo_len_d     = lo_len_q;
        match_d      = match_q;
        locked_d     = locked_q;
        meas_valid_d = 1'b0;
        err_d        = 1'b0;
        match_inc    = (match_q == LOCK_VAL) ? match_q : match_q + MATCH_1;

        unique case (state_q)
            IDLE: begin
                if (primed && !s) state_d = ARM;
            end
            ARM: begin
                if (rise) begin
                    state_d   = HIGH;
                    run_cnt_d = CNT_ONE;
                end
            end
            HIGH, LOW: begin
                if (run_cnt_q == CNT_MAX) begin
                    // A saturated run means the divided clock has stopped; this wins over an edge.
                    state_d   = IDLE;
                    run_cnt_d = '0;
                    err_d     = 1'b1;
                    match_d   = '0;
                    locked_d  = 1'b0;
                end else if (state_q == HIGH && fall) begin
                    state_d   = LOW;
                    hi_tmp_d  = run_cnt_q;
                    run_cnt_d = CNT_ONE;
                end else if (state_q == LOW && rise) begin
                    state_d      = HIGH;
                    run_cnt_d    = CNT_ONE;
                    hi_len_d     = hi_tmp_q;
                    lo_len_d     = run_cnt_q;
                    meas_valid_d = 1'b1;
                    if (hi_tmp_q == N_VAL && run_cnt_q == N_VAL) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_VAL) locked_d = 1'b1;
                    end else begin
                        err_d    = 1'b1;
                        match_d  = '0;
                        locked_d = 1'b0;
                    end
                end else begin
                    run_cnt_d = run_cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            prime_q      <= '0;
            s_q          <= 1'b0;
            state_q      <= IDLE;
            run_cnt_q    <= '0;
            hi_tmp_q     <= '0;
            hi_len_q     <= '0;
            lo_len_q     <= '0;
            match_q      <= '0;
            locked_q     <= 1'b0;
            meas_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sync_q       <= SYNC'({sync_q, mon.div_clk});
            prime_q      <= SYNC'({prime_q, 1'b1});
            s_q          <= s;
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            hi_tmp_q     <= hi_tmp_d;
            hi_len_q     <= hi_len_d;
            lo_len_q     <= lo_len_d;
            match_q      <= match_d;
            locked_q     <= locked_d;
            meas_valid_q <= meas_valid_d;
            err_q        <= err_d;
        end
    end

    assign mon.hi_len     = hi_len_q;
    assign mon.lo_len     = lo_len_q;
    assign mon.meas_valid = meas_valid_q;
    assign mon.locked     = locked_q;
    assign mon.err        = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor. It drives two instances (N=4/LOCK=3 and N=2/LOCK=1) and compares
// them against a run-length model of the sampled div_clk stream, delayed by the synchroniser.
module tb_clk_div_monitor;

    localparam int CNT_W   = 8;
    localparam int SYNC    = 2;
    localparam int LAT     = SYNC + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int N_A     = 4;
    localparam int LOCK_A  = 3;
    localparam int N_B     = 2;
    localparam int LOCK_B  = 1;

    typedef struct {
        int hi_len;
        int lo_len;
        bit meas_valid;
        bit locked;
        bit err;
    } obs_t;

    logic i_clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 i_clk = ~i_clk;

    clk_div_monitor_if #(.CNT_W(CNT_W)) if_a ();
    clk_div_monitor_if #(.CNT_W(CNT_W)) if_b ();

    clk_div_monitor #(.N(N_A), .LOCK_CNT(LOCK_A), .CNT_W(CNT_W), .SYNC(SYNC)) dut_a (
        .i_clk (i_clk),
        .rst_n (rst_n),
        .mon   (if_a)
    );

    clk_div_monitor #(.N(N_B), .LOCK_CNT(LOCK_B), .CNT_W(CNT_W), .SYNC(SYNC)) dut_b (
        .i_clk (i_clk),
        .rst_n (rst_n),
        .mon   (if_b)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    int   n_par[2]    = '{N_A, N_B};
    int   lock_par[2] = '{LOCK_A, LOCK_B};

    // Model: samples seen by the monitor, tracked as run lengths between edges.
    bit   m_prev[2];
    bit   m_seen_low[2];
    bit   m_counting[2];
    int   m_since[2];
    int   m_hi_run[2];
    int   m_match[2];
    int   m_meas_cnt[2];
    int   m_err_cnt[2];
    obs_t m_out[2];
    obs_t exp_q[2][$];

    bit   stim_q[2][$];
    bit   drive_val[2];
    int   dut_meas[2];
    int   dut_err[2];

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    function automatic obs_t read_dut(input int i);
        obs_t o;
        if (i == 0) begin
            o.hi_len = int'(if_a.hi_len); o.lo_len = int'(if_a.lo_len);
            o.meas_valid = if_a.meas_valid; o.locked = if_a.locked; o.err = if_a.err;
        end else begin
            o.hi_len = int'(if_b.hi_len); o.lo_len = int'(if_b.lo_len);
            o.meas_valid = if_b.meas_valid; o.locked = if_b.locked; o.err = if_b.err;
        end
        return o;
    endfunction

    task automatic model_reset(input int i);
        m_prev[i] = 1'b0; m_seen_low[i] = 1'b0; m_counting[i] = 1'b0;
        m_since[i] = 0; m_hi_run[i] = 0; m_match[i] = 0;
        m_out[i] = '{0, 0, 1'b0, 1'b0, 1'b0};
        exp_q[i].delete();
        repeat (LAT) exp_q[i].push_back(m_out[i]);
    endtask

    task automatic model_step(input int i, input bit v);
        obs_t o;
        bit   tmo;
        o = m_out[i]; o.meas_valid = 1'b0; o.err = 1'b0; tmo = 1'b0;
        m_since[i]++;
        if (m_counting[i] && m_since[i] == CNT_MAX) begin
            tmo = 1'b1; o.err = 1'b1; o.locked = 1'b0; m_match[i] = 0;
            m_counting[i] = 1'b0; m_seen_low[i] = 1'b0; m_err_cnt[i]++;
        end else if (m_counting[i] && v != m_prev[i]) begin
            if (!v) begin
                m_hi_run[i] = m_since[i];
            end else begin
                o.hi_len = m_hi_run[i]; o.lo_len = m_since[i]; o.meas_valid = 1'b1;
                m_meas_cnt[i]++;
                if (m_hi_run[i] == n_par[i] && m_since[i] == n_par[i]) begin
                    m_match[i] = (m_match[i] + 1 > lock_par[i]) ? lock_par[i] : m_match[i] + 1;
                    if (m_match[i] == lock_par[i]) o.locked = 1'b1;
                end else begin
                    o.err = 1'b1; o.locked = 1'b0; m_match[i] = 0; m_err_cnt[i]++;
                end
            end
            m_since[i] = 0;
        end else if (!m_counting[i] && m_seen_low[i] && v && !m_prev[i]) begin
            m_counting[i] = 1'b1; m_since[i] = 0;
        end
        if (!m_counting[i] && !tmo && !v) m_seen_low[i] = 1'b1;
        m_prev[i] = v;
        m_out[i]  = o;
    endtask

    // Called once per falling edge: compare outputs, then drive and model the next sample.
    task automatic step();
        obs_t e;
        obs_t a;
        for (int i = 0; i < 2; i++) begin
            e = exp_q[i].pop_front();
            a = read_dut(i);
            vectors++;
            if (a != e) begin
                miscompares++;
                $display("FAIL outputs_%0s t=%0t got hi=%0d lo=%0d mv=%0b lk=%0b err=%0b expected hi=%0d lo=%0d mv=%0b lk=%0b err=%0b",
                         (i == 0) ? "a" : "b", $time, a.hi_len, a.lo_len, a.meas_valid, a.locked,
                         a.err, e.hi_len, e.lo_len, e.meas_valid, e.locked, e.err);
            end
            dut_meas[i] += int'(a.meas_valid);
            dut_err[i]  += int'(a.err);
            if (stim_q[i].size() > 0) drive_val[i] = stim_q[i].pop_front();
            model_step(i, drive_val[i]);
            exp_q[i].push_back(m_out[i]);
        end
        if_a.div_clk = drive_val[0];
        if_b.div_clk = drive_val[1];
    endtask

    task automatic push_run(input int i, input bit v, input int len);
        repeat (len) stim_q[i].push_back(v);
    endtask

    task automatic push_period(input int i, input int hi, input int lo);
        push_run(i, 1'b1, hi);
        push_run(i, 1'b0, lo);
    endtask

    task automatic drain();
        int guard = 0;
        while ((stim_q[0].size() > 0 || stim_q[1].size() > 0) && guard < 40000) begin
            @(negedge i_clk);
            step();
            guard++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hi_a"}, int'(if_a.hi_len), 0);
        check({tag, "_lo_a"}, int'(if_a.lo_len), 0);
        check({tag, "_mv_a"}, int'(if_a.meas_valid), 0);
        check({tag, "_lk_a"}, int'(if_a.locked), 0);
        check({tag, "_err_a"}, int'(if_a.err), 0);
        check({tag, "_hi_b"}, int'(if_b.hi_len), 0);
        check({tag, "_lo_b"}, int'(if_b.lo_len), 0);
        check({tag, "_mv_b"}, int'(if_b.meas_valid), 0);
        check({tag, "_lk_b"}, int'(if_b.locked), 0);
        check({tag, "_err_b"}, int'(if_b.err), 0);
    endtask

    function automatic int rand_len(input int n);
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 13) return n;
        if (r < 16) return n + 1;
        if (r < 19) return n - 1;
        return 260;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_meas_cnt[i] = 0; m_err_cnt[i] = 0; dut_meas[i] = 0; dut_err[i] = 0;
            drive_val[i] = 1'b1;
        end
        if_a.div_clk = 1'b1;
        if_b.div_clk = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check_all_zero("reset");

        // Instance A is high at release; B starts low and tests single-period lock.
        @(negedge i_clk);
        rst_n = 1'b1;
        model_reset(0);
        model_reset(1);
        push_run(0, 1'b1, 6);
        push_run(0, 1'b0, 4);
        repeat (5) push_period(0, 4, 4);
        push_run(1, 1'b0, 2);
        repeat (2) push_period(1, 2, 2);
        push_period(1, 2, 1);
        repeat (2) push_period(1, 2, 2);
        push_run(1, 1'b1, 2);
        step();
        drain();
        check("p1_meas_a", m_meas_cnt[0], 4);
        check("p1_err_a", m_err_cnt[0], 0);
        check("p1_lock_a", int'(m_out[0].locked), 1);
        check("p1_hi_a", m_out[0].hi_len, 4);
        check("p1_meas_b", m_meas_cnt[1], 5);
        check("p1_err_b", m_err_cnt[1], 1);
        check("p1_lock_b", int'(m_out[1].locked), 1);

        // One long-high/short-low period breaks lock; two good periods follow.
        push_period(0, 5, 3);
        repeat (3) push_period(0, 4, 4);
        drain();
        check("p2_meas_a", m_meas_cnt[0], 8);
        check("p2_err_a", m_err_cnt[0], 1);
        check("p2_lock_a", int'(m_out[0].locked), 0);

        // Relock on the next rise, then a stalled low run times out.
        push_period(0, 4, 300);
        repeat (3) push_period(0, 4, 4);
        drain();
        check("p3_meas_a", m_meas_cnt[0], 11);
        check("p3_err_a", m_err_cnt[0], 2);
        check("p3_lock_a", int'(m_out[0].locked), 0);

        // Random periods around N with occasional stalls on both instances.
        repeat (40) push_period(0, rand_len(N_A), rand_len(N_A));
        repeat (60) push_period(1, rand_len(N_B), rand_len(N_B));
        drain();

        // Reset while A is measuring a high run.
        push_period(0, 4, 4);
        push_run(0, 1'b1, 6);
        push_period(1, 2, 2);
        push_run(1, 1'b1, 6);
        drain();
        @(posedge i_clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        repeat (3) @(negedge i_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            m_meas_cnt[i] = 0; m_err_cnt[i] = 0; dut_meas[i] = 0; dut_err[i] = 0;
        end
        push_run(0, 1'b0, 4);
        repeat (3) push_period(0, 4, 4);
        push_period(0, 4, 6);
        push_run(1, 1'b0, 3);
        push_period(1, 2, 2);
        push_run(1, 1'b1, 2);
        step();
        drain();
        repeat (LAT) begin
            @(negedge i_clk);
            step();
        end
        check("p5_meas_a", m_meas_cnt[0], 3);
        check("p5_lock_a", int'(m_out[0].locked), 1);
        check("p5_meas_b", m_meas_cnt[1], 1);
        check("p5_dut_meas_a", dut_meas[0], 3);
        check("p5_dut_err_a", dut_err[0], 0);
        check("p5_dut_meas_b", dut_meas[1], 1);
        check("p5_dut_err_b", dut_err[1], 0);
        check("p5_dut_lock_a", int'(if_a.locked), 1);
        check("p5_dut_lock_b", int'(if_b.locked), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
